md_sched: RTL and testbench
===========================

// Module: md_sched
// PURPOSE
//  Multi-cycle multiply/divide scheduler for the 5-stage MIPS pipeline.
//  - Accepts mult/multu/div/divu from EX and runs each for a fixed number of cycles.
//  - Owns the HI/LO registers and services mthi/mtlo.
//  - Raises Stall_MD so the ID-stage hazard logic freezes any HI/LO-using instruction
//    while the unit is occupied. Stall_MD is ORed with the existing stall.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   clock, all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  Start      in   1   EX holds mult/multu/div/divu this cycle
//  MDOp       in   2   0=mult 1=multu 2=div 3=divu; sampled only with Start
//  A          in   32  rs operand (EX, forwarded)
//  B          in   32  rt operand (EX, forwarded)
//  HIWrite    in   1   EX holds mthi
//  LOWrite    in   1   EX holds mtlo
//  WD         in   32  mthi/mtlo data (rs, forwarded)
//  isMD_ID    in   1   ID holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
//  Busy       out  1   operation in flight
//  HI         out  32  HI register (feeds mfhi in EX)
//  LO         out  32  LO register (feeds mflo in EX)
//  Stall_MD   out  1   combinational stall request for ID
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, Busy=0, HI=LO=0, result buffers=0, Stall_MD=0.
//    A reset during BUSY aborts the operation; HI/LO are not written.
//  - FSM states IDLE and BUSY.
//    - IDLE & Start: latch the full 64-bit result into buffers.
//      Load counter with MULT_CYCLES (MDOp[1]=0) or DIV_CYCLES (MDOp[1]=1). Go to BUSY.
//    - BUSY: counter decrements each cycle. When counter==1, write HI/LO from buffers,
//      clear counter and go to IDLE.
//  - Latency: Start in cycle T.
//    - Busy=1 in cycles T+1..T+N (N = cycle count).
//    - New HI/LO visible from cycle T+N+1; Busy=0 in T+N+1.
//    - A back-to-back Start is accepted in T+N+1.
//  - Busy = (state==BUSY), registered.
//  - Stall_MD = isMD_ID & (Start | Busy).
//    Covers the cycle the op is in EX and every busy cycle.
//  - mult: {HI,LO} = signed(A)*signed(B).
//  - multu: {HI,LO} = A*B, 64-bit unsigned.
//  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of A.
//  - divu: LO = A/B, HI = A%B, unsigned.
//  - Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
//  - mthi/mtlo:
//    - In IDLE with Start=0: HI (or LO) <= WD at the next edge.
//    - While BUSY or Start: the write is ignored (unreachable given Stall_MD).
//  - Start while BUSY is ignored: no relatch and no counter reload.
//  - Start together with HIWrite or LOWrite: Start wins; the write is dropped.
// CONFIGURATION
//  MD_DIV0_HOLD_EN
//  - Defined: div/divu with B==0 runs the full DIV_CYCLES with Busy asserted,
//    but HI/LO keep their prior values at completion.
//  - Undefined: div/divu with B==0 writes LO=0xFFFFFFFF, HI=A at completion.
//  - Timing is identical in both builds.
// TESTING
//  - Reset, then mult A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF,
//    LO=0xFFFFFFFA.
//  - multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
//  - div A=-7 (0xFFFFFFF9), B=2 -> Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    With isMD_ID=1 throughout, Stall_MD=1 for 11 cycles (Start cycle plus 10 busy).
//  - divu A=5, B=0 -> with MD_DIV0_HOLD_EN, HI/LO keep prior values;
//    without it, LO=0xFFFFFFFF, HI=5.
//  - mthi WD=0x1234 in IDLE -> HI=0x1234 next cycle. Start+LOWrite together -> LO takes
//    the op result, not WD.
//  - mult started, reset asserted on busy cycle 3 -> next cycle Busy=0, HI=LO=0;
//    no late write occurs.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler owning the HI/LO registers.
// Latency: Start in cycle T -> Busy in T+1..T+N, new HI/LO visible in T+N+1 (N = MULT_CYCLES or DIV_CYCLES).
// Backpressure: Stall_MD = isMD_ID & (Start | Busy) freezes HI/LO users in ID; Start while busy is ignored.
//
// Ports: clk, reset (sync, active-high), Start/MDOp/A/B (op issue from EX),
//        HIWrite/LOWrite/WD (mthi/mtlo), isMD_ID (ID holds an md-class instr),
//        Busy, HI, LO, Stall_MD (outputs).
// Optional build macro MD_DIV0_HOLD_EN: divide by zero leaves HI/LO untouched
// (same timing); otherwise it writes LO=0xFFFFFFFF, HI=A.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic [31:0] WD,
  input  logic        isMD_ID,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Stall_MD
);

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   hi_buf, lo_buf;
  logic [31:0]   hi_q, lo_q;
`ifdef MD_DIV0_HOLD_EN
  logic          div0_q;
`endif

  // Result datapath, evaluated from the EX operands in the Start cycle.
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;
  logic        is_signed, b_zero;
  logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;
  logic        q_neg, r_neg;
  logic [63:0] res;

  always_comb begin
    a_sx   = {{32{A[31]}}, A};
    b_sx   = {{32{B[31]}}, B};
    a_zx   = {32'd0, A};
    b_zx   = {32'd0, B};
    // Low 64 bits of a product of sign-extended operands equal the signed product.
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;

    // Signed division on magnitudes: avoids the INT_MIN / -1 overflow trap and
    // gives truncation toward zero with the remainder taking the sign of A.
    is_signed = ~MDOp[0];
    b_zero    = (B == 32'd0);
    a_mag     = (is_signed && A[31]) ? (~A + 32'd1) : A;
    b_mag     = (is_signed && B[31]) ? (~B + 32'd1) : B;
    divisor   = b_zero ? 32'd1 : b_mag;
    q_mag     = a_mag / divisor;
    r_mag     = a_mag % divisor;
    q_neg     = is_signed & (A[31] ^ B[31]);
    r_neg     = is_signed & A[31];
    quo       = q_neg ? (~q_mag + 32'd1) : q_mag;
    rem       = r_neg ? (~r_mag + 32'd1) : r_mag;

    res = 64'd0;
    case (MDOp)
      2'd0:    res = prod_s;
      2'd1:    res = prod_u;
      default: res = b_zero ? {A, 32'hFFFF_FFFF} : {rem, quo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      hi_buf <= '0;
      lo_buf <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
`ifdef MD_DIV0_HOLD_EN
      div0_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            // Start takes priority over a same-cycle mthi/mtlo.
            {hi_buf, lo_buf} <= res;
            count            <= MDOp[1] ? DIV_LD : MULT_LD;
            state            <= BUSY;
`ifdef MD_DIV0_HOLD_EN
            div0_q           <= MDOp[1] & b_zero;
`endif
          end else begin
            if (HIWrite) hi_q <= WD;
            if (LOWrite) lo_q <= WD;
          end
        end
        BUSY: begin
          if (count == CNT_ONE) begin
`ifdef MD_DIV0_HOLD_EN
            if (!div0_q) begin
              hi_q <= hi_buf;
              lo_q <= lo_buf;
            end
`else
            hi_q <= hi_buf;
            lo_q <= lo_buf;
`endif
            count <= '0;
            state <= IDLE;
          end else begin
            count <= count - CNT_ONE;
          end
        end
      endcase
    end
  end

  assign Busy     = (state == BUSY);
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign Stall_MD = isMD_ID & (Start | Busy);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed + randomized bench for md_sched against an arithmetic reference model.
// Latency: checks Busy/Stall_MD each cycle of an op and HI/LO in the cycle after completion.
// Backpressure: injects ignored Start/HIWrite pulses while busy and Start+LOWrite collisions.
module tb_md_sched;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  MDOp;
  logic [31:0] A, B, WD;
  logic        HIWrite, LOWrite, isMD_ID;
  logic        Busy, Stall_MD;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;

  // Reference copy of the architectural HI/LO registers.
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .WD(WD), .isMD_ID(isMD_ID),
    .Busy(Busy), .HI(HI), .LO(LO), .Stall_MD(Stall_MD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one op given the HI/LO values it may leave untouched.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] prev);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op == 2'd0) begin
      q = sa * sb;
      return q;
    end
    if (op == 2'd1) return ua * ub;
    if (b == 32'd0) begin
`ifdef MD_DIV0_HOLD_EN
      return prev;
`else
      return {a, 32'hFFFF_FFFF};
`endif
    end
    if (op == 2'd2) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Issue one op and follow it to completion, checking every cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic md_id, input logic collide,
                        input logic junk);
    int n;
    logic [63:0] e;
    n = op[1] ? DC : MC;
    e = model(op, a, b, {m_hi, m_lo});
    Start = 1'b1; MDOp = op; A = a; B = b; isMD_ID = md_id;
    LOWrite = collide; WD = $urandom;
    #1;
    chk({tag, "_stall_start"}, 32'(Stall_MD), 32'(md_id));
    tick;
    Start = 1'b0; LOWrite = 1'b0;
    for (int i = 1; i <= n; i++) begin
      Start = 1'b0; HIWrite = 1'b0;
      #0;
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      chk({tag, "_stall_busy"}, 32'(Stall_MD), 32'(md_id));
      if (junk && i == 2) begin
        // Both must be ignored while the unit is occupied.
        Start = 1'b1; MDOp = ~op; A = $urandom; B = $urandom;
        HIWrite = 1'b1; WD = $urandom;
      end
      tick;
    end
    Start = 1'b0; HIWrite = 1'b0;
    m_hi = e[63:32];
    m_lo = e[31:0];
    #0;
    chk({tag, "_busy_done"}, 32'(Busy), 32'd0);
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1; Start = 1'b0; MDOp = 2'd0; A = '0; B = '0;
    HIWrite = 1'b0; LOWrite = 1'b0; WD = '0; isMD_ID = 1'b1;
    m_hi = '0; m_lo = '0;
    tick; tick;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_stall", 32'(Stall_MD), 32'd0);
    reset = 1'b0;
    isMD_ID = 1'b0;
    tick;

    run_op("mult", 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
    chk("mult_hi_const", HI, 32'hFFFF_FFFF);
    chk("mult_lo_const", LO, 32'hFFFF_FFFA);

    // Back-to-back: issued in the completion cycle of the previous op.
    run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    chk("multu_hi_const", HI, 32'hFFFF_FFFE);
    chk("multu_lo_const", LO, 32'h0000_0001);

    run_op("div", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
    chk("div_hi_const", HI, 32'hFFFF_FFFF);
    chk("div_lo_const", LO, 32'hFFFF_FFFD);
    isMD_ID = 1'b1;
    #1;
    chk("stall_idle", 32'(Stall_MD), 32'd0);
    isMD_ID = 1'b0;

    run_op("divu0", 2'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
`ifdef MD_DIV0_HOLD_EN
    chk("divu0_hi_const", HI, 32'hFFFF_FFFF);
    chk("divu0_lo_const", LO, 32'hFFFF_FFFD);
`else
    chk("divu0_hi_const", HI, 32'd5);
    chk("divu0_lo_const", LO, 32'hFFFF_FFFF);
`endif

    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    chk("ovf_hi_const", HI, 32'd0);
    chk("ovf_lo_const", LO, 32'h8000_0000);

    HIWrite = 1'b1; WD = 32'h1234;
    tick;
    HIWrite = 1'b0; m_hi = 32'h1234;
    chk("mthi", HI, 32'h1234);
    chk("mthi_lo_kept", LO, m_lo);
    LOWrite = 1'b1; WD = 32'hCAFE_0001;
    tick;
    LOWrite = 1'b0; m_lo = 32'hCAFE_0001;
    chk("mtlo", LO, 32'hCAFE_0001);

    run_op("start_lowr", 2'd1, 32'd7, 32'd9, 1'b1, 1'b1, 1'b0);
    chk("start_lowr_lo_const", LO, 32'd63);

    for (int k = 0; k < 30; k++) begin
      op = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op("rand", op, ra, rb, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        WD = $urandom;
        if ($urandom_range(0, 1) == 1) begin
          HIWrite = 1'b1; m_hi = WD;
        end else begin
          LOWrite = 1'b1; m_lo = WD;
        end
        tick;
        HIWrite = 1'b0; LOWrite = 1'b0;
        chk("rand_mthilo_hi", HI, m_hi);
        chk("rand_mthilo_lo", LO, m_lo);
      end
    end

    // Abort mid-operation: make HI/LO nonzero first so the clear is visible.
    HIWrite = 1'b1; LOWrite = 1'b1; WD = 32'h5A5A_5A5A;
    tick;
    HIWrite = 1'b0; LOWrite = 1'b0;
    Start = 1'b1; MDOp = 2'd0; A = 32'd1000; B = 32'd1000; isMD_ID = 1'b1;
    tick;
    Start = 1'b0;
    tick; tick;
    chk("abort_busy_c3", 32'(Busy), 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    chk("abort_stall", 32'(Stall_MD), 32'd0);
    repeat (MC + 2) tick;
    chk("abort_no_late_hi", HI, 32'd0);
    chk("abort_no_late_lo", LO, 32'd0);
    chk("abort_no_late_busy", 32'(Busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
